// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI streaming accumulator.
// Holds the FSM state encoding, the fold-mode encoding and the READ opcode.
package spi_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    FINISH
  } SpiState;

  typedef enum logic [1:0] {
    FOLD_ADD = 2'd0,
    FOLD_XOR = 2'd1,
    FOLD_MAX = 2'd2
  } FoldMode;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCLK divider, MSB-first TX/RX shifters, bit counter.
// word_done marks the sampling edge of the last bit of a len-bit frame.
module spi_bit_engine
  import spi_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int TX_W    = 32,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              stop,
  input  logic [TX_W-1:0]   tx_data,
  input  logic [5:0]        len,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              bit_done,
  output logic              word_done,
  output logic [WORD_W-1:0] rx_word
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic              run_q, run_d;
  logic              sclk_q, sclk_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        lead_q, lead_d;
  logic [5:0]        bit_q, bit_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [WORD_W-1:0] rx_q, rx_d;

  logic tick;
  logic rise;
  logic fall;

  assign tick      = run_q && (div_q == DIV_MAX);
  assign rise      = tick && (lead_q == 2'd0) && !sclk_q;
  assign fall      = tick && sclk_q;
  assign rx_word   = {rx_q[WORD_W-2:0], miso};
  assign word_done = rise && (bit_q == len - 6'd1);
  assign bit_done  = fall;
  assign sclk      = sclk_q;
  assign mosi      = tx_q[TX_W-1];

  always_comb begin
    run_d  = run_q;
    sclk_d = sclk_q;
    div_d  = div_q;
    lead_d = lead_q;
    bit_d  = bit_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (tick) begin
      div_d = '0;
    end else if (run_q) begin
      div_d = div_q + 1'b1;
    end
    // one idle SCLK period after CS falls before the first rising edge
    if (tick && (lead_q != 2'd0)) begin
      lead_d = lead_q - 2'd1;
    end
    if (rise) begin
      sclk_d = 1'b1;
      rx_d   = rx_word;
      bit_d  = word_done ? 6'd0 : bit_q + 6'd1;
    end
    if (fall) begin
      sclk_d = 1'b0;
      tx_d   = {tx_q[TX_W-2:0], 1'b0};
    end
    if (load) begin
      run_d  = 1'b1;
      sclk_d = 1'b0;
      div_d  = '0;
      lead_d = 2'd2;
      bit_d  = 6'd0;
      tx_d   = tx_data;
      rx_d   = '0;
    end else if (stop) begin
      run_d  = 1'b0;
      sclk_d = 1'b0;
      div_d  = '0;
      lead_d = 2'd0;
      bit_d  = 6'd0;
      tx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      sclk_q <= 1'b0;
      div_q  <= '0;
      lead_q <= 2'd0;
      bit_q  <= 6'd0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      run_q  <= run_d;
      sclk_q <= sclk_d;
      div_q  <= div_d;
      lead_q <= lead_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

endmodule

// File: rtl/spi_stream_accum.sv
// SPI EEPROM streaming reader that folds each received word into an accumulator.
// Sequence: READ opcode, start address, then count words; add/xor/max fold.
module spi_stream_accum
  import spi_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 16,
  parameter int CLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       IN_start,
  input  logic [ADDR_W-1:0]          IN_addr,
  input  logic [CNT_W-1:0]           IN_count,
  input  logic [1:0]                 IN_mode,
  input  logic                       IN_cancel,
  input  logic                       IN_clear,
  input  logic [$clog2(ACC_W/4)-1:0] IN_nibSel,
  output logic                       OUT_busy,
  output logic                       OUT_done,
  output logic                       OUT_wordValid,
  output logic [WORD_W-1:0]          OUT_word,
  output logic [ACC_W-1:0]           OUT_acc,
  output logic [3:0]                 OUT_nib,
  output logic                       OUT_sclk,
  output logic                       OUT_cs,
  output logic                       OUT_mosi,
  input  logic                       IN_miso
);

  localparam int NIB_W = $clog2(ACC_W / 4);
  localparam int NIB_N = ACC_W / 4;
  localparam int TX_W  = 8 + ADDR_W;
  localparam int FIN_W = $clog2(2 * CLK_DIV) + 1;
  localparam logic [FIN_W-1:0] FIN_MAX = FIN_W'(2 * CLK_DIV - 1);

  SpiState           state_q, state_d;
  logic              cs_q, cs_d;
  logic              done_q, done_d;
  logic              wv_q, wv_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              last_q, last_d;
  logic [FIN_W-1:0]  fin_q, fin_d;

  logic              load;
  logic              stop;
  logic [5:0]        len;
  logic              bit_done;
  logic              word_done;
  logic [WORD_W-1:0] rx_word;
  logic [ACC_W-1:0]  acc_base;
  logic [3:0]        nib;

  function automatic logic [ACC_W-1:0] fold(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] w,
    input logic [1:0]       m
  );
    logic [ACC_W-1:0] r;
    case (m)
      FOLD_XOR: r = a ^ w;
      FOLD_MAX: r = (w > a) ? w : a;
      default:  r = a + w;
    endcase
    return r;
  endfunction

  spi_bit_engine #(
    .WORD_W  (WORD_W),
    .TX_W    (TX_W),
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .stop      (stop),
    .tx_data   ({SPI_CMD_READ, IN_addr}),
    .len       (len),
    .miso      (IN_miso),
    .sclk      (OUT_sclk),
    .mosi      (OUT_mosi),
    .bit_done  (bit_done),
    .word_done (word_done),
    .rx_word   (rx_word)
  );

  always_comb begin
    len = 6'(WORD_W);
    if (state_q == CMD) begin
      len = 6'd8;
    end else if (state_q == ADDR) begin
      len = 6'(ADDR_W);
    end
  end

  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    done_d   = 1'b0;
    wv_d     = 1'b0;
    word_d   = word_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    last_d   = last_q;
    fin_d    = fin_q;
    load     = 1'b0;
    stop     = 1'b0;
    acc_base = IN_clear ? '0 : acc_q;
    if (IN_clear) begin
      acc_d = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (IN_start) begin
          if (IN_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = CMD;
            cs_d    = 1'b0;
            load    = 1'b1;
            mode_d  = IN_mode;
            rem_d   = IN_count;
            last_d  = 1'b0;
          end
        end
      end
      CMD, ADDR: begin
        if (IN_cancel) begin
          state_d = FINISH;
          stop    = 1'b1;
          fin_d   = FIN_MAX;
        end else if (word_done) begin
          state_d = (state_q == CMD) ? ADDR : DATA;
        end
      end
      DATA: begin
        // cancel discards whatever word is in flight, even a complete one
        if (IN_cancel) begin
          state_d = FINISH;
          stop    = 1'b1;
          fin_d   = FIN_MAX;
        end else begin
          if (word_done) begin
            word_d = rx_word;
            wv_d   = 1'b1;
            acc_d  = fold(acc_base, ACC_W'(rx_word), mode_q);
            rem_d  = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              last_d = 1'b1;
            end
          end
          if (bit_done && last_q) begin
            state_d = FINISH;
            stop    = 1'b1;
            fin_d   = FIN_MAX;
          end
        end
      end
      FINISH: begin
        if (fin_q == '0) begin
          state_d = IDLE;
          cs_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          fin_d = fin_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NIB_N; i++) begin
      if (IN_nibSel == NIB_W'(i)) begin
        nib = acc_q[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      wv_q    <= 1'b0;
      word_q  <= '0;
      acc_q   <= '0;
      mode_q  <= 2'd0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      wv_q    <= wv_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      fin_q   <= fin_d;
    end
  end

  assign OUT_busy      = (state_q != IDLE);
  assign OUT_done      = done_q;
  assign OUT_wordValid = wv_q;
  assign OUT_word      = word_q;
  assign OUT_acc       = acc_q;
  assign OUT_nib       = nib;
  assign OUT_cs        = cs_q;

endmodule

// File: tb/tb_spi_stream_accum.sv
// Self-checking bench: default-width instance plus a byte-wide instance,
// each driven by a simple SPI EEPROM model.
module tb_spi_stream_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // default-parameter instance
  logic        a_start = 0, a_cancel = 0, a_clear = 0;
  logic [23:0] a_addr = 0;
  logic [15:0] a_count = 0;
  logic [1:0]  a_mode = 0;
  logic [2:0]  a_nibsel = 0;
  logic        a_busy, a_done, a_wv, a_sclk, a_cs, a_mosi, a_miso;
  logic [31:0] a_word, a_acc;
  logic [3:0]  a_nib;

  // byte-wide instance
  logic        b_start = 0, b_cancel = 0, b_clear = 0;
  logic [15:0] b_addr = 0;
  logic [15:0] b_count = 0;
  logic [1:0]  b_mode = 0;
  logic [1:0]  b_nibsel = 0;
  logic        b_busy, b_done, b_wv, b_sclk, b_cs, b_mosi, b_miso;
  logic [7:0]  b_word;
  logic [15:0] b_acc;
  logic [3:0]  b_nib;

  spi_stream_accum u_dut_a (
    .clk(clk), .rst_n(rst_n), .IN_start(a_start), .IN_addr(a_addr),
    .IN_count(a_count), .IN_mode(a_mode), .IN_cancel(a_cancel),
    .IN_clear(a_clear), .IN_nibSel(a_nibsel), .OUT_busy(a_busy),
    .OUT_done(a_done), .OUT_wordValid(a_wv), .OUT_word(a_word),
    .OUT_acc(a_acc), .OUT_nib(a_nib), .OUT_sclk(a_sclk), .OUT_cs(a_cs),
    .OUT_mosi(a_mosi), .IN_miso(a_miso)
  );

  spi_stream_accum #(
    .WORD_W(8), .ADDR_W(16), .ACC_W(16), .CNT_W(16), .CLK_DIV(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .IN_start(b_start), .IN_addr(b_addr),
    .IN_count(b_count), .IN_mode(b_mode), .IN_cancel(b_cancel),
    .IN_clear(b_clear), .IN_nibSel(b_nibsel), .OUT_busy(b_busy),
    .OUT_done(b_done), .OUT_wordValid(b_wv), .OUT_word(b_word),
    .OUT_acc(b_acc), .OUT_nib(b_nib), .OUT_sclk(b_sclk), .OUT_cs(b_cs),
    .OUT_mosi(b_mosi), .IN_miso(b_miso)
  );

  // EEPROM models: count SCLK rises, serve data after command + address
  logic [31:0] dat_a [8];
  logic [7:0]  dat_b [8];
  int idx_a = 0, idx_b = 0;
  logic ps_a = 0, ps_b = 0;
  logic [31:0] mcap_a = 0;
  int cslow_a = 0, cslow_b = 0;
  int nwv_a = 0, nwv_b = 0, ndone_a = 0, ndone_b = 0;

  always_comb begin
    int d;
    d = idx_a - 32;
    a_miso = 1'b0;
    if (d >= 0 && d < 256) a_miso = dat_a[d / 32][31 - (d % 32)];
  end

  always_comb begin
    int d;
    d = idx_b - 24;
    b_miso = 1'b0;
    if (d >= 0 && d < 64) b_miso = dat_b[d / 8][7 - (d % 8)];
  end

  always @(negedge clk) begin
    ps_a <= a_sclk;
    ps_b <= b_sclk;
    if (a_cs) idx_a <= 0;
    else if (a_sclk && !ps_a) begin
      idx_a <= idx_a + 1;
      if (idx_a < 32) mcap_a <= {mcap_a[30:0], a_mosi};
    end
    if (b_cs) idx_b <= 0;
    else if (b_sclk && !ps_b) idx_b <= idx_b + 1;
    if (!a_cs) cslow_a <= cslow_a + 1;
    if (!b_cs) cslow_b <= cslow_b + 1;
    if (a_wv) nwv_a <= nwv_a + 1;
    if (b_wv) nwv_b <= nwv_b + 1;
    if (a_done) ndone_a <= ndone_a + 1;
    if (b_done) ndone_b <= ndone_b + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0: return ndone_a;
      1: return ndone_b;
      2: return nwv_a;
      default: return nwv_b;
    endcase
  endfunction

  task automatic wait_cnt(input int sel, input int base, input string nm);
    bit hit;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (cnt_of(sel) != base);
    end
    chk(nm, 64'(hit), 64'd1);
  endtask

  task automatic start_a(input logic [23:0] ad, input logic [15:0] cn,
                         input logic [1:0] md);
    @(posedge clk); #1;
    a_start = 1; a_addr = ad; a_count = cn; a_mode = md;
    @(posedge clk); #1;
    a_start = 0;
  endtask

  task automatic start_b(input logic [15:0] cn, input logic [1:0] md);
    @(posedge clk); #1;
    b_start = 1; b_addr = 16'h0040; b_count = cn; b_mode = md;
    @(posedge clk); #1;
    b_start = 0;
  endtask

  typedef struct packed {
    logic        clr;
    logic [1:0]  mode;
    logic [15:0] cnt;
    logic [23:0] w;
    logic [15:0] exp_acc;
    logic [7:0]  exp_wv;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int bw, bd, bc;
    logic [2:0] nsel [5];
    logic [3:0] nexp [5];

    tbl[0] = '{1'b1, 2'd1, 16'd3, 24'hA50FFF, 16'h0055, 8'd3};
    tbl[1] = '{1'b1, 2'd2, 16'd3, 24'h10807F, 16'h0080, 8'd3};
    tbl[2] = '{1'b0, 2'd0, 16'd2, 24'h010200, 16'h0083, 8'd2};
    tbl[3] = '{1'b0, 2'd3, 16'd1, 24'h7D0000, 16'h0100, 8'd1};
    tbl[4] = '{1'b0, 2'd0, 16'd0, 24'h000000, 16'h0100, 8'd0};
    tbl[5] = '{1'b0, 2'd1, 16'd2, 24'h00FF00, 16'h01FF, 8'd2};
    nsel = '{3'd1, 3'd0, 3'd3, 3'd7, 3'd2};
    nexp = '{4'h3, 4'h4, 4'h1, 4'h0, 4'h2};
    for (int i = 0; i < 8; i++) begin
      dat_a[i] = 0;
      dat_b[i] = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", a_cs, 1);
    chk("rst_sclk_mosi", {a_sclk, a_mosi}, 0);
    chk("rst_flags", {a_busy, a_done, a_wv}, 0);
    chk("rst_word_acc", {a_word, a_acc}, 0);
    @(negedge clk) rst_n = 1;

    // reset in the middle of DATA
    dat_a[0] = 32'h12345678;
    dat_a[1] = 32'h00000001;
    bw = nwv_a;
    start_a(24'h000010, 16'd2, 2'd0);
    wait_cnt(2, bw, "midrst_wv_wait");
    chk("midrst_acc_before", a_acc, 32'h12345678);
    @(negedge clk) rst_n = 0;
    #1;
    chk("midrst_cs", a_cs, 1);
    chk("midrst_acc", a_acc, 0);
    chk("midrst_busy", a_busy, 0);
    @(negedge clk) rst_n = 1;

    // add with wrap, full timing
    dat_a[0] = 32'h00000005;
    dat_a[1] = 32'hFFFFFFFE;
    bw = nwv_a; bd = ndone_a; bc = cslow_a;
    start_a(24'h000100, 16'd2, 2'd0);
    wait_cnt(0, bd, "add_done_wait");
    chk("add_acc", a_acc, 32'h3);
    chk("add_wv_count", nwv_a - bw, 2);
    chk("add_word", a_word, 32'hFFFFFFFE);
    chk("add_mosi", mcap_a, 32'h03000100);
    chk("add_cs_low", cslow_a - bc, (8 + 24 + 64 + 2) * 2 * 2);
    chk("add_end_state", {a_cs, a_busy}, 2'b10);

    // cancel after ~1.5 words, with a start while busy
    @(posedge clk); #1 a_clear = 1;
    @(posedge clk); #1 a_clear = 0;
    dat_a[0] = 32'hAABBCCDD;
    dat_a[1] = 32'h11111111;
    dat_a[2] = 32'h22222222;
    dat_a[3] = 32'h33333333;
    bw = nwv_a; bd = ndone_a;
    start_a(24'h000000, 16'd4, 2'd0);
    wait_cnt(2, bw, "cancel_wv_wait");
    repeat (30) @(posedge clk);
    #1 a_start = 1; a_count = 16'd7;
    @(posedge clk); #1 a_start = 0;
    repeat (32) @(posedge clk);
    #1 a_cancel = 1;
    @(posedge clk); #1 a_cancel = 0;
    wait_cnt(0, bd, "cancel_done_wait");
    chk("cancel_acc", a_acc, 32'hAABBCCDD);
    chk("cancel_wv_count", nwv_a - bw, 1);
    chk("cancel_end_state", {a_cs, a_busy}, 2'b10);
    repeat (40) @(posedge clk);
    #1;
    chk("cancel_no_restart", {a_cs, 8'(ndone_a - bd), 8'(nwv_a - bw)},
        {1'b1, 8'd1, 8'd1});

    // nibble readout
    @(posedge clk); #1 a_clear = 1;
    @(posedge clk); #1 a_clear = 0;
    dat_a[0] = 32'h00001234;
    bd = ndone_a;
    start_a(24'h000000, 16'd1, 2'd0);
    wait_cnt(0, bd, "nib_done_wait");
    chk("nib_acc", a_acc, 32'h1234);
    for (int i = 0; i < 5; i++) begin
      a_nibsel = nsel[i];
      #1;
      chk($sformatf("nib_sel%0d", nsel[i]), a_nib, nexp[i]);
    end

    // byte-wide table
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].clr) begin
        @(posedge clk); #1 b_clear = 1;
        @(posedge clk); #1 b_clear = 0;
      end
      dat_b[0] = tbl[i].w[23:16];
      dat_b[1] = tbl[i].w[15:8];
      dat_b[2] = tbl[i].w[7:0];
      bw = nwv_b; bd = ndone_b; bc = cslow_b;
      start_b(tbl[i].cnt, tbl[i].mode);
      if (tbl[i].cnt == 0) chk($sformatf("v%0d_done_now", i), b_done, 1);
      wait_cnt(1, bd, $sformatf("v%0d_done_wait", i));
      chk($sformatf("v%0d_acc", i), b_acc, tbl[i].exp_acc);
      chk($sformatf("v%0d_wv", i), nwv_b - bw, tbl[i].exp_wv);
      chk($sformatf("v%0d_cs_low", i), cslow_b - bc,
          (tbl[i].cnt == 0) ? 0 : (24 + 8 * tbl[i].cnt + 2) * 2);
    end

    // clear on the very cycle a word commits
    dat_b[0] = 8'h09;
    bw = nwv_b; bd = ndone_b;
    start_b(16'd1, 2'd0);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(posedge clk); #1;
        hit = (idx_b == 31) && !b_sclk;
      end
      chk("clrc_align", 64'(hit), 1);
    end
    b_clear = 1;
    @(posedge clk); #1 b_clear = 0;
    wait_cnt(1, bd, "clrc_done_wait");
    chk("clrc_acc", b_acc, 16'h0009);
    chk("clrc_word", b_word, 8'h09);
    chk("clrc_wv", nwv_b - bw, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
